// File: rtl/pwm_edge_capture.sv
// rtl/pwm_edge_capture.sv - measures rise/fall times of a PWM waveform against a free-running period counter
// Each 256-cycle window of aligned time is classified and reported with a one-cycle VALID pulse.
module pwm_edge_capture #(
  parameter int LATENCY = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_time_cnt,
  input  logic       i_pwm_in,
  output logic [7:0] o_rise_out,
  output logic [7:0] o_fall_out,
  output logic       o_valid,
  output logic [1:0] o_err_code
);

  typedef enum logic [1:0] {SYNC, CAPTURE, REPORT} state_t;

  state_t     r_state, w_next;
  logic [7:0] w_t;
  logic [7:0] r_prev_t;
  logic       r_prev;
  logic [1:0] r_rise_cnt, r_fall_cnt;
  logic [7:0] r_rise_t, r_fall_t;
  logic       w_rise_edge, w_fall_edge, w_disc, w_win_end;
  logic [1:0] w_rise_base, w_fall_base, w_rise_n, w_fall_n;
  logic [7:0] w_rise_tn, w_fall_tn;
  logic [7:0] w_res_rise, w_res_fall;
  logic [1:0] w_res_err;

  // Align the counter with the PWM sample it produced
  generate
    if (LATENCY == 0) begin : g_nodly
      assign w_t = i_time_cnt;
    end else begin : g_dly
      logic [7:0] r_dly [LATENCY];
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < LATENCY; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= i_time_cnt;
          for (int i = 1; i < LATENCY; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_t = r_dly[LATENCY-1];
    end
  endgenerate

  assign w_rise_edge = ~r_prev & i_pwm_in;
  assign w_fall_edge = r_prev & ~i_pwm_in;
  assign w_disc      = (r_state != SYNC) && (w_t != 8'(r_prev_t + 8'd1));
  assign w_win_end   = (r_state == CAPTURE) && (w_t == 8'hFF);

  // The REPORT cycle carries the t=0 sample, so it starts a fresh window
  always_comb begin
    w_rise_base = (r_state == CAPTURE) ? r_rise_cnt : 2'd0;
    w_fall_base = (r_state == CAPTURE) ? r_fall_cnt : 2'd0;
    w_rise_n    = (w_rise_edge && w_rise_base != 2'd2) ? w_rise_base + 2'd1 : w_rise_base;
    w_fall_n    = (w_fall_edge && w_fall_base != 2'd2) ? w_fall_base + 2'd1 : w_fall_base;
    w_rise_tn   = w_rise_edge ? w_t : r_rise_t;
    w_fall_tn   = w_fall_edge ? w_t : r_fall_t;
  end

  always_comb begin
    w_res_rise = 8'd0;
    w_res_fall = 8'd0;
    w_res_err  = 2'd1;
    if (w_rise_n == 2'd1 && w_fall_n == 2'd1) begin
      w_res_rise = w_rise_tn;
      w_res_fall = w_fall_tn;
      w_res_err  = 2'd0;
    end else if (w_rise_n == 2'd0 && w_fall_n == 2'd0) begin
      w_res_err  = i_pwm_in ? 2'd2 : 2'd0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SYNC:    if (w_t == 8'hFF) w_next = CAPTURE;
      CAPTURE: if (w_disc) w_next = SYNC;
               else if (w_t == 8'hFF) w_next = REPORT;
      REPORT:  w_next = w_disc ? SYNC : CAPTURE;
      default: w_next = SYNC;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= SYNC;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev     <= 1'b0;
      r_prev_t   <= 8'd0;
      r_rise_cnt <= 2'd0;
      r_fall_cnt <= 2'd0;
      r_rise_t   <= 8'd0;
      r_fall_t   <= 8'd0;
      o_rise_out <= 8'd0;
      o_fall_out <= 8'd0;
      o_err_code <= 2'd0;
      o_valid    <= 1'b0;
    end else begin
      r_prev   <= i_pwm_in;
      r_prev_t <= w_t;
      o_valid  <= 1'b0;
      if (r_state == SYNC) begin
        r_rise_cnt <= 2'd0;
        r_fall_cnt <= 2'd0;
      end else begin
        r_rise_cnt <= w_rise_n;
        r_fall_cnt <= w_fall_n;
        r_rise_t   <= w_rise_tn;
        r_fall_t   <= w_fall_tn;
      end
      if (w_disc) begin
        o_valid    <= 1'b1;
        o_rise_out <= 8'd0;
        o_fall_out <= 8'd0;
        o_err_code <= 2'd3;
      end else if (w_win_end) begin
        o_valid    <= 1'b1;
        o_rise_out <= w_res_rise;
        o_fall_out <= w_res_fall;
        o_err_code <= w_res_err;
      end
    end
  end

endmodule

// File: doc/pwm_edge_capture.md
PWM_EDGE_CAPTURE -- requirements
Module: pwm_edge_capture

Interface
REQ-001 Parameter LATENCY, default 1, range 0..3: number of CLK cycles by which PWM_IN lags the TIME_CNT value that produced it.
REQ-002 CLK  input  1  sole clock; all logic on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 TIME_CNT  input  8  free-running period counter, 0..255, +1 per cycle, wraps 255->0.
REQ-005 PWM_IN  input  1  PWM waveform under observation.
REQ-006 RISE_OUT  output  8  captured rising-edge time of last completed window.
REQ-007 FALL_OUT  output  8  captured falling-edge time of last completed window.
REQ-008 VALID  output  1  one-cycle pulse: RISE_OUT/FALL_OUT/ERR_CODE updated.
REQ-009 ERR_CODE  output  2  0 ok, 1 multiple edges, 2 constant high, 3 TIME_CNT discontinuity.

Function
REQ-010 The block SHALL delay TIME_CNT by LATENCY register stages to form aligned time t, paired with the current PWM_IN sample.
REQ-011 The block SHALL register the previous PWM_IN sample (prev) for edge detection.
REQ-012 The block SHALL treat a window as aligned t=0..255; edge at t is the transition between samples at t-1 (mod 256) and t.
REQ-013 A rising edge (prev=0, cur=1) at t SHALL record t as rise time; a falling edge (prev=1, cur=0) at t SHALL record t as fall time.
REQ-014 Rise and fall counters SHALL be 2-bit saturating at 2, cleared at the start of each window.
REQ-015 FSM states: SYNC, CAPTURE, REPORT.
REQ-016 SYNC: entered from reset; ignores edges; on aligned t=255 latches prev and goes to CAPTURE.
REQ-017 CAPTURE: accumulates edges for t=0..255; on t=255 goes to REPORT while the t=0 sample of the next window is handled in CAPTURE (back-to-back windows, no dropped sample).
REQ-018 REPORT SHALL last exactly one cycle, driving VALID=1 and updating outputs, i.e. VALID asserts one cycle after aligned t=255 is sampled.
REQ-019 Result: exactly one rise and one fall -> RISE_OUT=rise time, FALL_OUT=fall time, ERR_CODE=0.
REQ-020 Result: no edges, level low -> RISE_OUT=0, FALL_OUT=0, ERR_CODE=0 (canonical zero duty).
REQ-021 Result: no edges, level high -> RISE_OUT=0, FALL_OUT=0, ERR_CODE=2 (unrepresentable by 8-bit rise/fall).
REQ-022 Result: any counter >=2, or exactly one of rise/fall seen -> RISE_OUT=0, FALL_OUT=0, ERR_CODE=1.
REQ-023 If aligned t != previous aligned t +1 (mod 256) in CAPTURE, the block SHALL abort the window, pulse VALID with ERR_CODE=3, outputs 0, and return to SYNC.
REQ-024 Rise at t>fall (wrap-around duty) SHALL be reported unchanged; no reordering.
REQ-025 RISE_OUT, FALL_OUT, ERR_CODE SHALL hold between VALID pulses.

Reset
REQ-026 RST=1 at any cycle SHALL, at that clock edge, set state=SYNC, RISE_OUT=0, FALL_OUT=0, ERR_CODE=0, VALID=0, counters=0, delay stages=0, prev=0.
REQ-027 After RST deasserts, the first VALID SHALL occur only after a full SYNC plus one complete CAPTURE window (no partial-window report).

Verification
REQ-028 Generator rise=64, fall=192, LATENCY=1 -> every VALID: RISE_OUT=64, FALL_OUT=192, ERR_CODE=0.
REQ-029 rise=192, fall=64 (wrap) -> RISE_OUT=192, FALL_OUT=64, ERR_CODE=0; rise=0, fall=128 -> RISE_OUT=0 (edge across wrap), FALL_OUT=128.
REQ-030 rise=fall=128 (PWM low) -> RISE_OUT=0, FALL_OUT=0, ERR_CODE=0; PWM_IN forced 1 -> ERR_CODE=2.
REQ-031 Two 4-cycle pulses at t=10 and t=100 in one window -> ERR_CODE=1; next clean window (rise=64, fall=192) -> ERR_CODE=0 with correct values.
REQ-032 TIME_CNT jumps 50->80 mid-window -> VALID with ERR_CODE=3 next cycle, then SYNC; later windows report correctly.
REQ-033 RST pulsed at aligned t=120 -> outputs 0 same edge; no VALID until SYNC and one full window complete; then correct values.
